// File: rtl/rx_bitalign_pkg.sv
// rx_bitalign_pkg: state encoding and eye record shared by the RX bit-alignment controller.
package rx_bitalign_pkg;

    // Eye fields are sized for the widest supported TAP_W; users cast down to TAP_W.
    localparam int EYE_W = 16;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD0,
        ST_CLR,
        ST_SETTLE,
        ST_SAMPLE,
        ST_STEP,
        ST_CENTER_LOAD,
        ST_CENTER_MOVE,
        ST_NEXT,
        ST_DONE
    } rx_bitalign_state_t;

    typedef struct packed {
        logic [EYE_W-1:0] start;
        logic [EYE_W-1:0] len;
    } rx_bitalign_eye_t;

endpackage

// File: rtl/rx_bitalign_eye_track.sv
// rx_bitalign_eye_track: tracks the current clean-tap run and the widest run seen, and derives its centre.
module rx_bitalign_eye_track
    import rx_bitalign_pkg::*;
#(
    parameter int TAP_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             smp,
    input  logic             good,
    input  logic             last,
    input  logic [TAP_W-1:0] tap,
    output logic [TAP_W-1:0] best_start,
    output logic [TAP_W-1:0] best_len,
    output logic [TAP_W-1:0] centre
);

    rx_bitalign_eye_t run_q, run_d, best_q, best_d, eff;

    always_comb begin
        eff = '{start: (good && run_q.len == '0) ? EYE_W'(tap) : run_q.start,
                len:   run_q.len + EYE_W'(good)};
        run_d  = run_q;
        best_d = best_q;
        if (clr) begin
            run_d  = '0;
            best_d = '0;
        end else if (smp) begin
            run_d = eff;
            // Strictly greater keeps the lower-start eye on a tie.
            if (!good || last) begin
                run_d.len = '0;
                best_d    = (eff.len > best_q.len) ? eff : best_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q  <= '0;
            best_q <= '0;
        end else begin
            run_q  <= run_d;
            best_q <= best_d;
        end
    end

    assign best_start = TAP_W'(best_q.start);
    assign best_len   = TAP_W'(best_q.len);
    assign centre     = TAP_W'(best_q.start + (best_q.len >> 1));

endmodule

// File: rtl/rx_iod_bitalign_mlane.sv
// rx_iod_bitalign_mlane: per-lane IOD tap sweep that parks each delay at its widest eye centre.
// Define RX_BITALIGN_WIN_REPORT_EN to add the BIT_ALGN_LEFT_WIN/BIT_ALGN_RGHT_WIN eye-edge outputs.
module rx_iod_bitalign_mlane
    import rx_bitalign_pkg::*;
#(
    parameter int LANES   = 4,
    parameter int TAP_W   = 8,
    parameter int TAP_MAX = 127,
    parameter int WAIT_W  = 3,
    parameter int MIN_EYE = 4
) (
    input  logic                                       SCLK,
    input  logic                                       RESETN,
    input  logic                                       PLL_LOCK,
    input  logic                                       BIT_ALGN_RSTRT,
    input  logic                                       BIT_ALGN_SKIP,
    input  logic [LANES-1:0]                           IOD_EARLY,
    input  logic [LANES-1:0]                           IOD_LATE,
    input  logic [LANES-1:0]                           IOD_OOR,
    output logic                                       BIT_ALGN_START,
    output logic                                       BIT_ALGN_DONE,
    output logic [LANES-1:0]                           BIT_ALGN_ERR,
    output logic [LANES-1:0]                           BIT_ALGN_CLR_FLGS,
    output logic [LANES-1:0]                           BIT_ALGN_LOAD,
    output logic [LANES-1:0]                           BIT_ALGN_MOVE,
    output logic                                       BIT_ALGN_DIR,
    output logic [(LANES > 1 ? $clog2(LANES) : 1)-1:0] LANE_SEL,
`ifdef RX_BITALIGN_WIN_REPORT_EN
    output logic [LANES*TAP_W-1:0]                     BIT_ALGN_LEFT_WIN,
    output logic [LANES*TAP_W-1:0]                     BIT_ALGN_RGHT_WIN,
`endif
    output logic [LANES*TAP_W-1:0]                     BIT_ALGN_TAPDLY
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    rx_bitalign_state_t     state_q, state_d;
    logic [LW-1:0]          lane_q, lane_d;
    logic [TAP_W-1:0]       tap_q, tap_d, mv_q, mv_d;
    logic [WAIT_W-1:0]      wait_q, wait_d;
    logic [LANES*TAP_W-1:0] tapdly_q, tapdly_d;
    logic [LANES-1:0]       err_q, err_d, lane_oh;
    logic                   good, last, eye_bad, mv_last, wr_lane;
    logic [TAP_W-1:0]       best_start, best_len, centre;

    assign good    = !IOD_EARLY[lane_q] && !IOD_LATE[lane_q] && !IOD_OOR[lane_q];
    assign last    = IOD_OOR[lane_q] || tap_q == TAP_W'(TAP_MAX);
    assign eye_bad = best_len < TAP_W'(MIN_EYE);
    assign mv_last = mv_q + TAP_W'(1) == centre;
    assign wr_lane = (state_q == ST_CENTER_LOAD && (eye_bad || centre == '0)) ||
                     (state_q == ST_CENTER_MOVE && mv_last);

    rx_bitalign_eye_track #(.TAP_W(TAP_W)) u_eye (
        .clk        (SCLK),
        .rst_n      (RESETN),
        .clr        (state_q == ST_LOAD0),
        .smp        (state_q == ST_SAMPLE),
        .good       (good),
        .last       (last),
        .tap        (tap_q),
        .best_start (best_start),
        .best_len   (best_len),
        .centre     (centre)
    );

    always_ff @(posedge SCLK or negedge RESETN) begin
        if (!RESETN) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:        if (PLL_LOCK) state_d = BIT_ALGN_SKIP ? ST_DONE : ST_LOAD0;
            ST_LOAD0:       state_d = ST_CLR;
            ST_CLR:         state_d = ST_SETTLE;
            ST_SETTLE:      if (&wait_q) state_d = ST_SAMPLE;
            ST_SAMPLE:      state_d = last ? ST_CENTER_LOAD : ST_STEP;
            ST_STEP:        state_d = ST_CLR;
            ST_CENTER_LOAD: state_d = (eye_bad || centre == '0) ? ST_NEXT : ST_CENTER_MOVE;
            ST_CENTER_MOVE: if (mv_last) state_d = ST_NEXT;
            ST_NEXT:        state_d = (lane_q == LW'(LANES - 1)) ? ST_DONE : ST_LOAD0;
            ST_DONE:        state_d = ST_DONE;
            default:        state_d = ST_IDLE;
        endcase
        if ((!PLL_LOCK && state_q != ST_IDLE) || BIT_ALGN_RSTRT) state_d = ST_IDLE;
    end

    always_comb begin
        lane_oh           = LANES'(1) << lane_q;
        BIT_ALGN_LOAD     = (state_q == ST_LOAD0 || state_q == ST_CENTER_LOAD) ? lane_oh : '0;
        BIT_ALGN_CLR_FLGS = (state_q == ST_CLR) ? lane_oh : '0;
        BIT_ALGN_MOVE     = (state_q == ST_STEP || state_q == ST_CENTER_MOVE) ? lane_oh : '0;
        BIT_ALGN_START    = state_q != ST_IDLE && state_q != ST_DONE;
        BIT_ALGN_DONE     = state_q == ST_DONE;
    end

    always_comb begin
        tap_d    = (state_q == ST_LOAD0) ? '0 : (state_q == ST_STEP) ? tap_q + TAP_W'(1) : tap_q;
        wait_d   = (state_q == ST_SETTLE) ? wait_q + WAIT_W'(1) : '0;
        mv_d     = (state_q == ST_CENTER_MOVE) ? mv_q + TAP_W'(1) : '0;
        lane_d   = (state_q == ST_IDLE) ? '0 :
                   (state_q == ST_NEXT && lane_q != LW'(LANES - 1)) ? lane_q + LW'(1) : lane_q;
        tapdly_d = tapdly_q;
        err_d    = err_q;
        if (BIT_ALGN_RSTRT) begin
            tapdly_d = '0;
            err_d    = '0;
        end else if (wr_lane) begin
            tapdly_d[lane_q*TAP_W +: TAP_W] = eye_bad ? '0 : centre;
            err_d[lane_q]                   = err_q[lane_q] | eye_bad;
        end
    end

    always_ff @(posedge SCLK or negedge RESETN) begin
        if (!RESETN) begin
            lane_q   <= '0;
            tap_q    <= '0;
            mv_q     <= '0;
            wait_q   <= '0;
            tapdly_q <= '0;
            err_q    <= '0;
        end else begin
            lane_q   <= lane_d;
            tap_q    <= tap_d;
            mv_q     <= mv_d;
            wait_q   <= wait_d;
            tapdly_q <= tapdly_d;
            err_q    <= err_d;
        end
    end

`ifdef RX_BITALIGN_WIN_REPORT_EN
    logic [LANES*TAP_W-1:0] left_q, left_d, rght_q, rght_d;

    always_comb begin
        left_d = left_q;
        rght_d = rght_q;
        if (BIT_ALGN_RSTRT) begin
            left_d = '0;
            rght_d = '0;
        end else if (wr_lane) begin
            left_d[lane_q*TAP_W +: TAP_W] = eye_bad ? '0 : best_start;
            rght_d[lane_q*TAP_W +: TAP_W] = eye_bad ? '0 : best_start + best_len - TAP_W'(1);
        end
    end

    always_ff @(posedge SCLK or negedge RESETN) begin
        if (!RESETN) begin
            left_q <= '0;
            rght_q <= '0;
        end else begin
            left_q <= left_d;
            rght_q <= rght_d;
        end
    end

    assign BIT_ALGN_LEFT_WIN = left_q;
    assign BIT_ALGN_RGHT_WIN = rght_q;
`else
    logic win_unused;
    assign win_unused = ^best_start;
`endif

    assign BIT_ALGN_TAPDLY = tapdly_q;
    assign BIT_ALGN_ERR    = err_q;
    assign BIT_ALGN_DIR    = 1'b1;
    assign LANE_SEL        = lane_q;

endmodule
